// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: prescaled sequencer for a DEPTH-stage clock-enabled delay chain.
// Words enter stage 0 on each tick, shift one stage per tick, and are presented
// from the latched tap stage. Stop drains the chain with bubbles before idling.
module delay_line_ctrl #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int DIV_WIDTH = 8,
  localparam int TAP_W    = $clog2(DEPTH),
  localparam int FILL_W   = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [TAP_W-1:0]     tap,
  input  logic                 in_valid,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 ce_o,
  output logic [FILL_W-1:0]    fill,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                          r_state;
  logic [DIV_WIDTH-1:0]            r_cnt;
  logic [DIV_WIDTH-1:0]            r_div_q;
  logic [TAP_W-1:0]                r_tap_q;
  logic [DEPTH-1:0][BUS_WIDTH-1:0] r_stage;
  logic [DEPTH-1:0]                r_v;
  logic                            r_out_valid;

  logic                            w_tick;
  logic                            w_accept;
  logic [DEPTH-1:0]                w_vin;
  logic [FILL_W-1:0]               w_fill;

  // Tick only while the chain is active; in_ready only while new words are welcome.
  assign w_tick   = (r_state != S_IDLE) && (r_cnt == r_div_q);
  assign w_accept = in_valid && w_tick && (r_state == S_RUN);
  // Valid bits as they will look after the next tick; used to predict the tap pulse.
  assign w_vin    = {r_v[DEPTH-2:0], w_accept};

  assign ce_o      = w_tick;
  assign in_ready  = w_tick && (r_state == S_RUN);
  assign out_valid = r_out_valid;
  assign out_data  = r_stage[r_tap_q];
  assign busy      = (r_state != S_IDLE);
  assign fill      = w_fill;

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    w_fill = '0;
    for (int i = 0; i < DEPTH; i++) w_fill = w_fill + FILL_W'(r_v[i]);
  end

  // Control FSM and prescaler; div/tap are captured only when leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div_q <= '0;
      r_tap_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state <= S_RUN;
            r_div_q <= div;
            r_tap_q <= tap;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (stop) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (r_v == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Delay chain: shift on tick, inserting a zero bubble when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage     <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_tick && w_vin[r_tap_q];
      if (w_tick) begin
        r_v        <= w_vin;
        r_stage[0] <= w_accept ? in_data : '0;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, stop, in_valid;
  logic [7:0] div, in_data;
  logic [2:0] tap;
  logic       in_ready, out_valid, ce_o, busy;
  logic [7:0] out_data;
  logic [3:0] fill;

  int n_chk = 0;
  int n_pass = 0;

  delay_line_ctrl #(.BUS_WIDTH(8), .DEPTH(8), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div), .tap(tap),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .ce_o(ce_o), .fill(fill), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic go(input logic [7:0] d, input logic [2:0] t);
    div = d; tap = t; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run(input string nm);
    bit ok;
    stop = 1'b1; step(); stop = 1'b0; in_valid = 1'b0;
    wait_idle(ok);
    n_chk++;
    if (!ok) $display("FAIL %s_drain: busy still 1 after 100 cycles, required 0", nm);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_chk++;
    if ({busy, in_ready, out_valid, ce_o, fill, out_data} !== 16'h0)
      $display("FAIL reset_init: busy=%b rdy=%b ov=%b ce=%b fill=%0d od=%h required all 0",
               busy, in_ready, out_valid, ce_o, fill, out_data);
    else n_pass++;
    rst = 1'b0;
    // Mid-run reset with three words in flight.
    go(8'd0, 3'd7);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 8'hC0 + 8'(i); step(); end
    in_valid = 1'b0;
    n_chk++;
    if (fill !== 4'd3) $display("FAIL reset_prefill: fill=%0d required 3", fill);
    else n_pass++;
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_chk++;
    if ({busy, out_valid, ce_o, in_ready, fill} !== 8'h0)
      $display("FAIL reset_midrun: busy=%b ov=%b ce=%b rdy=%b fill=%0d required all 0",
               busy, out_valid, ce_o, in_ready, fill);
    else n_pass++;
    step();
    n_chk++;
    if ({busy, ce_o, out_data} !== 10'h0)
      $display("FAIL reset_after: busy=%b ce=%b od=%h required 0", busy, ce_o, out_data);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [7:0] exp_w [3];
    exp_w[0] = 8'hA1; exp_w[1] = 8'hA2; exp_w[2] = 8'hA3;
    go(8'd0, 3'd2);
    n_chk++;
    if (ce_o !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL lat_first_tick: ce=%b rdy=%b required 1 1", ce_o, in_ready);
    else n_pass++;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL lat_early_%0d: ov=%b required 0", i, out_valid);
      else n_pass++;
      in_data = exp_w[i]; step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i])
        $display("FAIL lat_word_%0d: ov=%b od=%h required 1 %h", i, out_valid, out_data, exp_w[i]);
      else n_pass++;
      step();
    end
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL lat_tail: ov=%b required 0", out_valid);
    else n_pass++;
    finish_run("lat");
  endtask

  task automatic test_prescale();
    int bad = 0;
    in_valid = 1'b1; in_data = 8'h55;
    go(8'd3, 3'd0);
    for (int i = 0; i < 12; i++) begin
      logic e_tick, e_ov;
      e_tick = (i % 4 == 3);
      e_ov   = (i % 4 == 0) && (i > 0);
      n_chk++;
      if (ce_o !== e_tick || in_ready !== e_tick || out_valid !== e_ov ||
          (e_ov && out_data !== 8'h55)) begin
        $display("FAIL presc_cyc%0d: ce=%b rdy=%b ov=%b od=%h required %b %b %b 55",
                 i, ce_o, in_ready, out_valid, out_data, e_tick, e_tick, e_ov);
        bad++;
      end else n_pass++;
      step();
    end
    in_valid = 1'b0;
    finish_run("presc");
  endtask

  task automatic test_fill();
    logic [3:0] exp_f [5];
    int gap;
    exp_f[0] = 1; exp_f[1] = 1; exp_f[2] = 1; exp_f[3] = 1; exp_f[4] = 2;
    go(8'd0, 3'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 0 || i == 4);
      in_data  = (i == 0) ? 8'h11 : 8'h22;
      step();
      n_chk++;
      if (fill !== exp_f[i]) $display("FAIL fill_step%0d: fill=%0d required %0d", i, fill, exp_f[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    step(); step(); step();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h11)
      $display("FAIL fill_w11: ov=%b od=%h required 1 11", out_valid, out_data);
    else n_pass++;
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (out_valid) begin gap = i; break; end
    end
    n_chk++;
    if (gap !== 4 || out_data !== 8'h22)
      $display("FAIL fill_w22: gap=%0d od=%h required 4 22", gap, out_data);
    else n_pass++;
    finish_run("fill");
  endtask

  task automatic test_flush();
    int k = 0, guard = 0, ncap = 0;
    bit rdy_seen = 0, ce_seen = 0;
    logic [7:0] cap [4];
    go(8'd1, 3'd3);
    in_valid = 1'b1; in_data = 8'h31;
    while (k < 4 && guard < 50) begin
      if (in_ready) begin step(); k++; in_data = 8'h31 + 8'(k); end
      else step();
      guard++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (fill !== 4'd4 || out_valid !== 1'b1 || out_data !== 8'h31)
      $display("FAIL flush_pre: fill=%0d ov=%b od=%h required 4 1 31", fill, out_valid, out_data);
    else n_pass++;
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      if (in_ready) rdy_seen = 1;
      if (ce_o) ce_seen = 1;
      if (out_valid && ncap < 4) begin cap[ncap] = out_data; ncap++; end
      step();
    end
    n_chk++;
    if (rdy_seen || !ce_seen)
      $display("FAIL flush_rdy: in_ready_seen=%b ce_seen=%b required 0 1", rdy_seen, ce_seen);
    else n_pass++;
    n_chk++;
    if (ncap !== 3) $display("FAIL flush_count: words=%0d required 3", ncap);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= ncap || cap[i] !== 8'h32 + 8'(i))
        $display("FAIL flush_word%0d: got %h required %h", i, (i < ncap) ? cap[i] : 8'hxx, 8'h32 + 8'(i));
      else n_pass++;
    end
    n_chk++;
    if (busy !== 1'b0 || fill !== 4'd0)
      $display("FAIL flush_idle: busy=%b fill=%0d required 0 0", busy, fill);
    else n_pass++;
  endtask

  task automatic test_start_stop();
    bit ok;
    div = 8'd0; tap = 3'd1; start = 1'b1; stop = 1'b1; step();
    start = 1'b0; stop = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || ce_o !== 1'b0)
      $display("FAIL ss_idle: busy=%b ce=%b required 0 0", busy, ce_o);
    else n_pass++;
    go(8'd0, 3'd1);
    tap = 3'd5;
    in_valid = 1'b1; in_data = 8'h66; step();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL ss_tap_early: ov=%b required 0", out_valid);
    else n_pass++;
    step();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h66)
      $display("FAIL ss_tap_hold: ov=%b od=%h required 1 66", out_valid, out_data);
    else n_pass++;
    start = 1'b1; stop = 1'b1; step();
    start = 1'b0; stop = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL ss_run_flush: busy=%b rdy=%b required 1 0", busy, in_ready);
    else n_pass++;
    wait_idle(ok);
    n_chk++;
    if (!ok) $display("FAIL ss_drain: busy still 1, required 0");
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    div = '0; tap = '0; in_data = '0;
    #1;
    test_reset();
    test_latency();
    test_prescale();
    test_fill();
    test_flush();
    test_start_stop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
